function_sequencer: RTL
=======================

# function_sequencer

Programmable sequencer that drives the waveform-select and phase-increment inputs of the function generator. It holds a small table of (waveform, delta, duration) entries, which are written through a config port. On `start` it plays the entries back to back, optionally looping. It sits between the control/register logic and the function generator and is the only block that drives `sel`/`delta`.

## Interface
- `DEPTH`, 8: number of table entries (≥2).
- `DELTA_W`, 8: width of the delta / phase increment.
- `DUR_W`, 16: width of the per-entry duration, in clock cycles.
- `AW`, $clog2(DEPTH): table address width (derived, not overridden).

- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `cfg_we` in 1: table write strobe.
- `cfg_addr` in AW: entry index to write.
- `cfg_sel` in type_t: waveform for the entry.
- `cfg_delta` in DELTA_W: delta for the entry.
- `cfg_dur` in DUR_W: duration for the entry; 0 is treated as 1.
- `cfg_last` in 1: marks the entry as the end of the sequence.
- `start` in 1: begin playback at entry 0.
- `stop` in 1: abort playback.
- `loop` in 1: repeat the sequence; sampled only on an accepted `start`.
- `fg_sel` out type_t: waveform select to the generator.
- `fg_delta` out DELTA_W: delta to the generator; 0 freezes the generator.
- `busy` out 1: high while playback is active.
- `step` out 1: one-cycle pulse each time a new entry is applied, including entry 0.
- `done` out 1: one-cycle pulse on natural sequence end (never on `stop`).

## Operation
- FSM states: IDLE and RUN (enum in the package).
- Reset values:
  - all outputs: `fg_sel`=type_t'(0), `fg_delta`=0, `busy`=0, `step`=0, `done`=0.
  - state IDLE, index 0, counter 0, `loop_q`=0.
  - all table fields 0.
- Config writes:
  - Accepted only in IDLE; ignored while `busy`.
  - `cfg_addr` ≥ DEPTH is ignored.
- IDLE → RUN on `start`=1 and `stop`=0:
  - load entry 0 into `fg_sel`/`fg_delta`.
  - set counter = max(dur,1) and index = 0.
  - `loop_q` = `loop`; pulse `step`.
- RUN, counter > 1: decrement the counter; outputs hold.
- RUN, counter == 1, which is the entry boundary. The next index is `last` ? 0 : index+1, and it also wraps to 0 after DEPTH−1.
  - Next index ≠ 0: load that entry, reload the counter, pulse `step`.
  - Wrap with `loop_q`=1: load entry 0, reload the counter, pulse `step`.
  - Wrap with `loop_q`=0: go to IDLE, set `fg_delta`=0, hold `fg_sel`, pulse `done`, index = 0.
- RUN with `stop`=1: go to IDLE the next edge.
  - `fg_delta`=0, index = 0.
  - No `done` or `step` pulse.
  - `stop` takes priority over the boundary.
- `start` while in RUN is ignored; a restart needs `stop` and then `start`.
- `start`+`stop` together in IDLE: stay in IDLE.
- Arithmetic: the counter is DUR_W unsigned and never underflows, because a duration of 0 is mapped to 1 at load. The index is AW bits with an explicit wrap.

## Timing
- All outputs are registered.
- `start` sampled at edge k: entry 0 appears on `fg_*` after edge k, and `busy`=1 and `step`=1 in the same cycle.
- Each entry is presented for exactly max(dur,1) cycles, with no gap cycles between entries or on a loop wrap.
- Natural end: one cycle after the final entry's last cycle, `busy`=0, `done`=1 for one cycle, `fg_delta`=0.
- `stop` at edge j: `busy`=0 and `fg_delta`=0 after edge j.
- A new `start` is accepted from the cycle after `busy` falls.
- `rst_n` low mid-run: immediate return to the reset values, table included.

## Structure
- Package `PKG_FunctionSequencer`:
  - `state_t` (IDLE, RUN).
  - `entry_t` packed struct {type_t sel; delta; dur; last}.
  - It imports `PKG_FunctionGenerator::type_t`; that package is not duplicated.
- Sub-module `function_seq_table`:
  - DEPTH×`entry_t` register file.
  - Async-reset clear, one write port, one combinational read port.
- Top-level `function_sequencer` holds the FSM, counter, index and output registers.

## Test plan
- **Basic:** table {TRIANGLE, 1, 5}, {entry 1, 4, 3, last}; start.
  - Entry 0 for 5 cycles, then entry 1 for 3 cycles.
  - `step` pulses at cycles 0 and 5; `done` at cycle 8; `fg_delta`=0 afterwards.
- **Zero duration:** entry 0 dur=0, entry 1 dur=2 last.
  - Entry 0 is held 1 cycle, then entry 1 for 2 cycles.
- **Loop:** same table as Basic with `loop`=1, run 20 cycles, then `stop`.
  - Period is 8 cycles with no gap at the wrap; no `done`.
  - `busy` falls the cycle after `stop`.
- **Full wrap:** no `last` set anywhere, DEPTH=8, all durations 2.
  - 8 entries over 16 cycles, then `done`.
- **Locked config:** `cfg_we` to entry 0 and `start` pulses while busy.
  - Table contents are unchanged and playback is not restarted.
- **Reset mid-run:** `rst_n` low at cycle 3 of Basic.
  - All outputs return to the reset values immediately and the table reads back as all zeros.

Source files
------------

// File: rtl/function_generator_pkg.sv
// -----------------------------------------------------------------------------
// PKG_FunctionGenerator
// Shared types of the function generator. The sequencer imports the waveform
// select type from here so both blocks agree on the encoding.
// -----------------------------------------------------------------------------
package PKG_FunctionGenerator;

   typedef enum logic [1:0] {
      SINE     = 2'd0,
      SQUARE   = 2'd1,
      TRIANGLE = 2'd2,
      SAWTOOTH = 2'd3
   } type_t;

endpackage : PKG_FunctionGenerator

// File: rtl/function_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// PKG_FunctionSequencer
// Types and helpers for the function sequencer:
//   state_t   - playback FSM state (IDLE, RUN)
//   entry_t   - one table entry {sel, delta, dur, last}
//   clamp_dur - maps a programmed duration of 0 to 1
// -----------------------------------------------------------------------------
package PKG_FunctionSequencer;

   import PKG_FunctionGenerator::type_t;

   // Field widths of a table entry. The top-level DELTA_W / DUR_W parameters
   // default to these and must stay equal to them.
   localparam int SEQ_DELTA_W = 8;
   localparam int SEQ_DUR_W   = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      type_t                  sel;
      logic [SEQ_DELTA_W-1:0] delta;
      logic [SEQ_DUR_W-1:0]   dur;
      logic                   last;
   } entry_t;

   // A zero duration would underflow the down-counter; present it for one cycle.
   function automatic logic [SEQ_DUR_W-1:0] clamp_dur(input logic [SEQ_DUR_W-1:0] dur);
      return (dur == '0) ? SEQ_DUR_W'(1) : dur;
   endfunction

endpackage : PKG_FunctionSequencer

// File: rtl/function_seq_table.sv
// -----------------------------------------------------------------------------
// function_seq_table
// DEPTH x entry_t register file holding the playback sequence.
// Cleared by the asynchronous reset, one synchronous write port, one
// combinational read port.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   we, waddr, wdata  write strobe / index / entry (caller qualifies range)
//   raddr, rdata    combinational read
// -----------------------------------------------------------------------------
module function_seq_table
   import PKG_FunctionSequencer::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  entry_t        wdata,
   input  logic [AW-1:0] raddr,
   output entry_t        rdata
);

   entry_t mem_reg [DEPTH];

   // One register per entry so the whole table clears on reset.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mem_reg[gi] <= '0;
            end else if (we && (waddr == AW'(gi))) begin
               mem_reg[gi] <= wdata;
            end
         end
      end
   endgenerate

   // raddr is generated internally and is always a valid index.
   assign rdata = mem_reg[raddr];

endmodule : function_seq_table

// File: rtl/function_sequencer.sv
// -----------------------------------------------------------------------------
// function_sequencer
// Plays a programmable table of (waveform, delta, duration) entries into the
// function generator's sel/delta inputs, optionally looping.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_we, cfg_addr, cfg_sel,
//   cfg_delta, cfg_dur,
//   cfg_last                   table write port (accepted only while idle)
//   start, stop, loop          playback control (loop sampled on start)
//   fg_sel, fg_delta           registered drive to the function generator
//   busy                       playback active
//   step                       pulse whenever a new entry is applied
//   done                       pulse on natural end of the sequence
// -----------------------------------------------------------------------------
module function_sequencer
   import PKG_FunctionGenerator::*;
   import PKG_FunctionSequencer::*;
#(
   parameter  int DEPTH   = 8,
   parameter  int DELTA_W = SEQ_DELTA_W,
   parameter  int DUR_W   = SEQ_DUR_W,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_we,
   input  logic [AW-1:0]      cfg_addr,
   input  type_t              cfg_sel,
   input  logic [DELTA_W-1:0] cfg_delta,
   input  logic [DUR_W-1:0]   cfg_dur,
   input  logic               cfg_last,
   input  logic               start,
   input  logic               stop,
   input  logic               loop,
   output type_t              fg_sel,
   output logic [DELTA_W-1:0] fg_delta,
   output logic               busy,
   output logic               step,
   output logic               done
);

   state_t             state_reg,    state_next;
   logic [AW-1:0]      index_reg,    index_next;
   logic [DUR_W-1:0]   count_reg,    count_next;
   logic               last_reg,     last_next;
   logic               loop_reg,     loop_next;
   type_t              fg_sel_reg,   fg_sel_next;
   logic [DELTA_W-1:0] fg_delta_reg, fg_delta_next;
   logic               step_reg,     step_next;
   logic               done_reg,     done_next;

   logic               addr_ok;
   logic               tbl_we;
   entry_t             tbl_wdata;
   logic [AW-1:0]      rd_addr;
   entry_t             rd_entry;
   logic [AW-1:0]      next_idx;
   logic               at_boundary;
   logic               wrap;

   // Out-of-range addresses only exist when DEPTH is not a power of two.
   generate
      if (DEPTH == (1 << AW)) begin : g_addr_full
         assign addr_ok = 1'b1;
      end else begin : g_addr_partial
         assign addr_ok = ({1'b0, cfg_addr} < (AW + 1)'(DEPTH));
      end
   endgenerate

   assign tbl_we    = cfg_we && addr_ok && (state_reg == IDLE);
   assign tbl_wdata = '{sel: cfg_sel, delta: cfg_delta, dur: cfg_dur, last: cfg_last};

   function_seq_table #(
      .DEPTH (DEPTH)
   ) u_table (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (tbl_we),
      .waddr (cfg_addr),
      .wdata (tbl_wdata),
      .raddr (rd_addr),
      .rdata (rd_entry)
   );

   // The current entry's last flag is kept in last_reg so the following index
   // is known without a second table read port.
   assign next_idx    = (last_reg || (index_reg == AW'(DEPTH - 1))) ? '0 : index_reg + AW'(1);
   assign at_boundary = (count_reg == DUR_W'(1));
   assign wrap        = (next_idx == '0);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         index_reg    <= '0;
         count_reg    <= '0;
         last_reg     <= 1'b0;
         loop_reg     <= 1'b0;
         fg_sel_reg   <= type_t'(0);
         fg_delta_reg <= '0;
         step_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         index_reg    <= index_next;
         count_reg    <= count_next;
         last_reg     <= last_next;
         loop_reg     <= loop_next;
         fg_sel_reg   <= fg_sel_next;
         fg_delta_reg <= fg_delta_next;
         step_reg     <= step_next;
         done_reg     <= done_next;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if (start && !stop) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_next = IDLE;
            end else if (at_boundary && wrap && !loop_reg) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------ output / data
   always_comb begin
      index_next    = index_reg;
      count_next    = count_reg;
      last_next     = last_reg;
      loop_next     = loop_reg;
      fg_sel_next   = fg_sel_reg;
      fg_delta_next = fg_delta_reg;
      step_next     = 1'b0;
      done_next     = 1'b0;
      rd_addr       = '0;

      unique case (state_reg)
         IDLE: begin
            if (start && !stop) begin
               fg_sel_next   = rd_entry.sel;
               fg_delta_next = rd_entry.delta;
               count_next    = clamp_dur(rd_entry.dur);
               last_next     = rd_entry.last;
               index_next    = '0;
               loop_next     = loop;
               step_next     = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               // Abort wins over any entry boundary in the same cycle.
               fg_delta_next = '0;
               index_next    = '0;
            end else if (!at_boundary) begin
               count_next = count_reg - DUR_W'(1);
            end else if (!wrap || loop_reg) begin
               rd_addr       = next_idx;
               fg_sel_next   = rd_entry.sel;
               fg_delta_next = rd_entry.delta;
               count_next    = clamp_dur(rd_entry.dur);
               last_next     = rd_entry.last;
               index_next    = next_idx;
               step_next     = 1'b1;
            end else begin
               // Natural end: freeze the generator but keep the last waveform.
               fg_delta_next = '0;
               index_next    = '0;
               done_next     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign fg_sel   = fg_sel_reg;
   assign fg_delta = fg_delta_reg;
   assign busy     = (state_reg == RUN);
   assign step     = step_reg;
   assign done     = done_reg;

endmodule : function_sequencer
